// File: rtl/pattern_pkg.sv
// ============================================================================
// Module      : pattern_pkg
// Description : Shared mode encodings and bounce-direction constants for
//               the pattern_reg block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pattern_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD   = 3'b000;
    localparam logic [MODE_W-1:0] MODE_INV    = 3'b001;
    localparam logic [MODE_W-1:0] MODE_ROL    = 3'b010;
    localparam logic [MODE_W-1:0] MODE_ROR    = 3'b011;
    localparam logic [MODE_W-1:0] MODE_INC    = 3'b100;
    localparam logic [MODE_W-1:0] MODE_DEC    = 3'b101;
    localparam logic [MODE_W-1:0] MODE_BOUNCE = 3'b110;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Divide-by-DIV clock-enable generator; en_out is high in the
//               last cycle of each DIV-cycle period. clr restarts the period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int DIV = 12000000
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic clr,
    output logic en_out
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr || (r_count == c_last)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign en_out = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/pattern_reg.sv
// ============================================================================
// Module      : pattern_reg
// Description : WIDTH-bit pattern register updated once per prescaled tick
//               by a runtime-selected mode (hold/invert/rotate/count/bounce).
//               Optional bounce mode enabled by macro PATTERN_BOUNCE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pattern_reg
    import pattern_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter int               DIV   = 12000000,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_data,
    output logic [WIDTH-1:0]  dout,
    output logic              tick,
    output logic              GREEN
);

    logic             w_en;
    logic [WIDTH-1:0] r_dout;
    logic             r_tick;
    logic [WIDTH-1:0] w_next;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr    (load),
        .en_out (w_en)
    );

`ifdef PATTERN_BOUNCE_EN
    logic             r_dir;
    logic             w_bounce_dir;
    logic [WIDTH-1:0] w_bounce;

    // A set end bit reverses direction and the same tick already moves away from it.
    always_comb begin
        w_bounce     = r_dout;
        w_bounce_dir = r_dir;
        if ((WIDTH > 1) && (r_dout != '0)) begin
            if (r_dir == DIR_LEFT) begin
                if (r_dout[WIDTH-1]) begin
                    w_bounce_dir = DIR_RIGHT;
                    w_bounce     = r_dout >> 1;
                end else begin
                    w_bounce     = r_dout << 1;
                end
            end else begin
                if (r_dout[0]) begin
                    w_bounce_dir = DIR_LEFT;
                    w_bounce     = r_dout << 1;
                end else begin
                    w_bounce     = r_dout >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_dir <= DIR_LEFT;
        end else if (load) begin
            r_dir <= DIR_LEFT;
        end else if (w_en && (mode == MODE_BOUNCE)) begin
            r_dir <= w_bounce_dir;
        end
    end
`endif

    // Shift-based rotates collapse to identity when WIDTH is 1.
    always_comb begin
        w_next = r_dout;
        case (mode)
            MODE_INV: w_next = ~r_dout;
            MODE_ROL: w_next = (r_dout << 1) | (r_dout >> (WIDTH - 1));
            MODE_ROR: w_next = (r_dout >> 1) | (r_dout << (WIDTH - 1));
            MODE_INC: w_next = r_dout + WIDTH'(1);
            MODE_DEC: w_next = r_dout - WIDTH'(1);
`ifdef PATTERN_BOUNCE_EN
            MODE_BOUNCE: w_next = w_bounce;
`endif
            default: w_next = r_dout;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= INIT;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_en & ~load;
            if (load) begin
                r_dout <= load_data;
            end else if (w_en) begin
                r_dout <= w_next;
            end
        end
    end

    assign dout  = r_dout;
    assign tick  = r_tick;
    assign GREEN = ~r_dout[0];

endmodule

`default_nettype wire

// File: doc/pattern_reg.md
Name: pattern_reg

Overview:
- Parametrised successor to the fixed 4-bit blink register: a WIDTH-bit output register updated once per prescaled tick.
- The update is selected by a runtime mode: hold, invert, rotate, count, or (optional) bounce.
- The prescaler is an integer divide-by-DIV clock enable, not a derived clock. The whole block runs on clk_in.
- Drives board LEDs (dout) and a status LED (GREEN).

Parameters:
- WIDTH, 4: register width in bits, >= 1.
- DIV, 12000000: prescaler terminal count, >= 1. One tick every DIV clk_in cycles.
- INIT, 1: reset and initial value of dout, WIDTH bits.

Ports:
- clk_in  in  1  system clock; every flop is posedge clk_in.
- rst_n  in  1  reset; asynchronous and active-low.
- mode  in  3  update operation applied at each tick.
- load  in  1  single-cycle strobe; loads load_data.
- load_data  in  WIDTH  value captured when load=1.
- dout  out  WIDTH  pattern register.
- tick  out  1  registered one-cycle pulse marking an update cycle.
- GREEN  out  1  equals ~dout[0], combinational from dout.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert is external):
  - dout=INIT, prescaler count=0, tick=0, GREEN=~INIT[0].
  - Bounce direction = left.
- Prescaler:
  - Count runs 0..DIV-1, then wraps to 0.
  - The internal tick enable is high in the cycle count==DIV-1.
  - With DIV=1 the enable is high every cycle.
  - The count register is $clog2(DIV) bits, minimum 1.
- tick output:
  - Registered copy of "dout updated this cycle by mode".
  - Goes high the cycle after the enable, i.e. coincident with the new dout value.
  - Not asserted for loads.
- Update at enable, using mode sampled in that same cycle:
  - 000 hold.
  - 001 invert: dout <= ~dout.
  - 010 rotate left: MSB goes to bit 0.
  - 011 rotate right: bit 0 goes to MSB.
  - 100 count up, modulo 2^WIDTH (all-ones -> 0).
  - 101 count down, modulo 2^WIDTH (0 -> all-ones).
  - 110 bounce if PATTERN_BOUNCE_EN is defined, otherwise hold.
  - 111 hold.
- Mode changes between ticks have no effect until the next enable. There is no latency beyond that.
- load:
  - In the cycle load=1, dout <= load_data next edge.
  - The prescaler count resets to 0, so the next mode update is exactly DIV cycles after the load edge.
  - Bounce direction resets to left.
- Simultaneous load and enable: load wins, no mode update, tick stays 0.
- WIDTH=1: rotates and bounce degenerate to hold. Invert and count toggle bit 0.
- Reset mid-count: the prescaler restarts from 0, so the first enable comes DIV cycles after rst_n deasserts.

Optional Feature:
- Macro: PATTERN_BOUNCE_EN.
- Defined:
  - Adds a direction flop, reset to left.
  - Mode 110 shifts one place in the current direction with zero fill, no wrap.
  - Moving left with dout[WIDTH-1]=1: direction flips to right, and this tick shifts right.
  - Moving right with dout[0]=1: direction flips to left, and this tick shifts left.
  - dout=0 stays 0.
- Undefined: no direction flop; mode 110 is hold.

Decomposition:
- Shared package pattern_pkg holds:
  - Mode localparams MODE_HOLD, MODE_INV, MODE_ROL, MODE_ROR, MODE_INC, MODE_DEC, MODE_BOUNCE.
  - The mode width constant, MODE_W=3.
- Sub-module tick_gen (parameter DIV; ports clk_in, rst_n, clr, en_out) holds the prescaler.
- pattern_reg instantiates tick_gen, with clr driven by load.

Test Plan (WIDTH=4, DIV=3, INIT=4'b0001 unless stated):
- Reset: hold rst_n=0 mid-run, asynchronous with the clock -> immediately dout=0001, GREEN=0, tick=0. First tick arrives 3 cycles after release.
- Invert: mode=001 -> dout 0001,1110,0001 on successive ticks; GREEN 0,1,0; tick pulses exactly once per 3 cycles.
- Rotate: mode=010 -> 0010,0100,1000,0001. Then mode=011 -> 1000,0100.
- Count down: load 0000, mode=101 -> 1111,1110. Count up from 1111 -> 0000.
- Load collision: assert load with load_data=1010 in the enable cycle -> dout=1010, no tick. The next update (mode=001 -> 0101) lands exactly 3 cycles later.
- Bounce (PATTERN_BOUNCE_EN defined): mode=110 from 0001 -> 0010,0100,1000,0100,0010,0001,0010. Without the macro, mode=110 holds 0001.
